// File: rtl/param_register_file.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : param_register_file
//  Brief    : 2-read/1-write register file with optional hard-wired zero
//             entry and a sequential scrub engine. Optional same-cycle
//             write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module param_register_file #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [WIDTH-1:0]  data,
    input  logic              clear,
    output logic [WIDTH-1:0]  outA,
    output logic [WIDTH-1:0]  outB,
    output logic              busy,
    output logic              wrDropped
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SCRUB = 1'b1
    } state_t;

    state_t              r_state_q;
    state_t              w_state_d;
    logic [ADDR_W-1:0]   r_ptr_q;
    logic [ADDR_W-1:0]   w_ptr_d;
    logic [WIDTH-1:0]    r_mem_q [DEPTH];
    logic [WIDTH-1:0]    w_mem_d [DEPTH];

    logic                w_zero_rd;
    logic                w_wr_acc;

    // Writes to a hard-wired zero entry vanish without raising wrDropped.
    assign w_zero_rd = (ZERO_REG != 0) && (rd == '0);
    assign w_wr_acc  = regWrite && (r_state_q == S_IDLE) && !w_zero_rd;
    assign wrDropped = regWrite && (r_state_q == S_SCRUB) && !reset;
    assign busy      = (r_state_q == S_SCRUB);

    always_comb begin
        w_state_d = r_state_q;
        w_ptr_d   = r_ptr_q;
        case (r_state_q)
            S_IDLE: begin
                if (clear) begin
                    w_state_d = S_SCRUB;
                    w_ptr_d   = '0;
                end
            end
            S_SCRUB: begin
                w_ptr_d = r_ptr_q + 1'b1;
                if (r_ptr_q == '1) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_ptr_d   = '0;
            end
        endcase
    end

    // Scrub and write never coincide: writes are only accepted while idle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_mem_d[i] = r_mem_q[i];
            if ((r_state_q == S_SCRUB) && (r_ptr_q == ADDR_W'(i))) begin
                w_mem_d[i] = '0;
            end else if (w_wr_acc && (rd == ADDR_W'(i))) begin
                w_mem_d[i] = data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= S_IDLE;
            r_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            r_state_q <= w_state_d;
            r_ptr_q   <= w_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= w_mem_d[i];
            end
        end
    end

    always_comb begin
        outA = r_mem_q[rs];
        outB = r_mem_q[rt];
        if ((ZERO_REG != 0) && (rs == '0)) begin
            outA = '0;
        end
        if ((ZERO_REG != 0) && (rt == '0)) begin
            outB = '0;
        end
`ifdef REGFILE_BYPASS_EN
        if (w_wr_acc && (rd == rs)) begin
            outA = data;
        end
        if (w_wr_acc && (rd == rt)) begin
            outB = data;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_param_register_file.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_param_register_file
//  Brief    : Directed scoreboard bench for param_register_file (32x32, r0=0).
//  Revision : 1.0  initial release
// ============================================================================
module tb_param_register_file;

    localparam int c_width  = 32;
    localparam int c_addr_w = 5;
    localparam int c_k_a    = 0;
    localparam int c_k_b    = 1;
    localparam int c_k_busy = 2;
    localparam int c_k_drop = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                regWrite;
    logic [c_addr_w-1:0] rs;
    logic [c_addr_w-1:0] rt;
    logic [c_addr_w-1:0] rd;
    logic [c_width-1:0]  data;
    logic                clear;
    logic [c_width-1:0]  outA;
    logic [c_width-1:0]  outB;
    logic                busy;
    logic                wrDropped;

    param_register_file #(
        .WIDTH    (c_width),
        .ADDR_W   (c_addr_w),
        .ZERO_REG (1)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .regWrite  (regWrite),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .data      (data),
        .clear     (clear),
        .outA      (outA),
        .outB      (outB),
        .busy      (busy),
        .wrDropped (wrDropped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          q_cyc  [$];
    int          q_kind [$];
    logic [31:0] q_val  [$];
    string       q_name [$];
    int          checks = 0;
    int          errors = 0;

    task automatic expect_out(input int kind, input logic [31:0] val, input string name);
        q_cyc.push_back(cyc);
        q_kind.push_back(kind);
        q_val.push_back(val);
        q_name.push_back(name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops every expectation tagged for the current cycle.
    always @(negedge clk) begin
        logic [31:0] act;
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            case (q_kind[0])
                c_k_a:    act = outA;
                c_k_b:    act = outB;
                c_k_busy: act = {31'b0, busy};
                default:  act = {31'b0, wrDropped};
            endcase
            checks++;
            if (q_cyc[0] < cyc) begin
                errors++;
                $display("FAIL %s: stale expectation from cycle %0d (now %0d)", q_name[0], q_cyc[0], cyc);
            end else if (act !== q_val[0]) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", q_name[0], cyc, act, q_val[0]);
            end
            void'(q_cyc.pop_front());
            void'(q_kind.pop_front());
            void'(q_val.pop_front());
            void'(q_name.pop_front());
        end
    end

    initial begin
        reset = 1'b1; regWrite = 1'b0; rs = '0; rt = '0; rd = '0; data = '0; clear = 1'b0;
        step();

        // reset state
        reset = 1'b0; rs = 5'd3; rt = 5'd31;
        expect_out(c_k_a, 32'h0, "rst_outA");
        expect_out(c_k_b, 32'h0, "rst_outB");
        expect_out(c_k_busy, 32'h0, "rst_busy");
        expect_out(c_k_drop, 32'h0, "rst_drop");
        step();

        // basic write then read
        regWrite = 1'b1; rd = 5'd4; data = 32'h1234_1235; rs = 5'd4; rt = 5'd4;
`ifdef REGFILE_BYPASS_EN
        expect_out(c_k_a, 32'h1234_1235, "wr4_same_outA");
`else
        expect_out(c_k_a, 32'h0, "wr4_same_outA");
`endif
        step();
        regWrite = 1'b0;
        expect_out(c_k_a, 32'h1234_1235, "wr4_outA");
        expect_out(c_k_b, 32'h1234_1235, "wr4_outB");
        regWrite = 1'b1; rd = 5'd7; data = 32'hA5A5_5A5A;
        step();
        regWrite = 1'b0; rs = 5'd4; rt = 5'd7;
        expect_out(c_k_a, 32'h1234_1235, "rd4_outA");
        expect_out(c_k_b, 32'hA5A5_5A5A, "rd7_outB");
        step();

        // hard-wired zero entry
        regWrite = 1'b1; rd = 5'd0; data = 32'hFFFF_FFFF; rs = 5'd0; rt = 5'd0;
        expect_out(c_k_a, 32'h0, "r0_same_outA");
        expect_out(c_k_drop, 32'h0, "r0_drop");
        step();
        regWrite = 1'b0;
        expect_out(c_k_a, 32'h0, "r0_outA");
        expect_out(c_k_b, 32'h0, "r0_outB");
        step();

        // fill 1..31 with own index, then read back
        for (int i = 1; i < 32; i++) begin
            regWrite = 1'b1; rd = 5'(i); data = 32'(i);
            expect_out(c_k_drop, 32'h0, "fill_drop");
            step();
        end
        regWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i); rt = 5'(31 - i);
            expect_out(c_k_a, 32'(i), "fill_outA");
            expect_out(c_k_b, 32'(31 - i), "fill_outB");
            step();
        end

        // clear pulse together with a write that must still land
        clear = 1'b1; regWrite = 1'b1; rd = 5'd9; data = 32'h99;
        expect_out(c_k_busy, 32'h0, "clr_busy");
        expect_out(c_k_drop, 32'h0, "clr_drop");
        step();
        for (int k = 0; k < 32; k++) begin
            clear    = (k == 5);
            regWrite = (k == 3) || (k == 10);
            rd       = 5'd6;
            data     = (k == 3) ? 32'hDEAD_0003 : 32'hBEEF_0010;
            rs       = 5'(k);
            rt       = (k == 0) ? 5'd31 : 5'(k - 1);
            expect_out(c_k_busy, 32'h1, "scrub_busy");
            expect_out(c_k_drop, ((k == 3) || (k == 10)) ? 32'h1 : 32'h0, "scrub_drop");
            expect_out(c_k_a, (k == 9) ? 32'h99 : 32'(k), "scrub_outA");
            expect_out(c_k_b, (k == 0) ? 32'd31 : 32'h0, "scrub_outB");
            step();
        end
        clear = 1'b0; regWrite = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rs = 5'(2 * i); rt = 5'(2 * i + 1);
            expect_out(c_k_busy, 32'h0, "post_busy");
            expect_out(c_k_a, 32'h0, "post_outA");
            expect_out(c_k_b, 32'h0, "post_outB");
            step();
        end

        // reset in the middle of a scrub
        for (int i = 1; i < 32; i++) begin
            regWrite = 1'b1; rd = 5'(i); data = 32'h100 + 32'(i);
            step();
        end
        regWrite = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rs = 5'd20;
            expect_out(c_k_busy, 32'h1, "mid_busy");
            expect_out(c_k_a, 32'h114, "mid_outA");
            step();
        end
        reset = 1'b1; regWrite = 1'b1; rd = 5'd20; data = 32'h777;
        expect_out(c_k_drop, 32'h0, "rstmid_drop");
        expect_out(c_k_busy, 32'h1, "rstmid_busy");
        step();
        reset = 1'b0; regWrite = 1'b0; rs = 5'd20; rt = 5'd30;
        expect_out(c_k_busy, 32'h0, "after_rst_busy");
        expect_out(c_k_a, 32'h0, "after_rst_outA");
        expect_out(c_k_b, 32'h0, "after_rst_outB");
        step();
        rs = 5'd11; rt = 5'd31;
        expect_out(c_k_a, 32'h0, "after_rst_r11");
        expect_out(c_k_b, 32'h0, "after_rst_r31");
        step();

        // same-cycle read of an entry being written
        regWrite = 1'b1; rd = 5'd6; data = 32'h5434_5675;
        step();
        rs = 5'd6; rt = 5'd6; data = 32'h5555_8888;
`ifdef REGFILE_BYPASS_EN
        expect_out(c_k_a, 32'h5555_8888, "byp_outA");
        expect_out(c_k_b, 32'h5555_8888, "byp_outB");
`else
        expect_out(c_k_a, 32'h5434_5675, "byp_outA");
        expect_out(c_k_b, 32'h5434_5675, "byp_outB");
`endif
        step();
        regWrite = 1'b0;
        expect_out(c_k_a, 32'h5555_8888, "byp_next_outA");
        expect_out(c_k_b, 32'h5555_8888, "byp_next_outB");
        step();

        // no forwarding of a dropped write while busy
        clear = 1'b1;
        step();
        clear = 1'b0; regWrite = 1'b1; rd = 5'd20; rs = 5'd20; data = 32'hABC;
        expect_out(c_k_a, 32'h0, "busy_nobyp_outA");
        expect_out(c_k_drop, 32'h1, "busy_nobyp_drop");
        step();
        regWrite = 1'b0;
        for (int k = 1; k < 32; k++) begin
            expect_out(c_k_busy, 32'h1, "scrub2_busy");
            step();
        end
        expect_out(c_k_busy, 32'h0, "scrub2_done");
        expect_out(c_k_a, 32'h0, "scrub2_r20");
        step();

        for (int n = 0; n < 5 && q_cyc.size() > 0; n++) begin
            step();
        end
        if (q_cyc.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked", q_cyc.size());
            errors += q_cyc.size();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
